// File: rtl/pixel_stream_source.sv
// Multi-slot image buffer feeding a raster pixel stream with valid/ready backpressure.
// Slots are loaded through a write port while another committed slot streams out.
module pixel_stream_source #(
   parameter int IMG_W     = 28,
   parameter int IMG_H     = 28,
   parameter int PIX_BITS  = 8,
   parameter int NUM_SLOTS = 2,
   parameter int SLOT_BITS = 1,
   parameter int ADDR_BITS = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_en,
   input  logic [SLOT_BITS-1:0] wr_slot,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic [PIX_BITS-1:0]  wr_data,
   input  logic                 wr_commit,
   output logic [NUM_SLOTS-1:0] slot_loaded,
   input  logic                 start,
   input  logic [SLOT_BITS-1:0] start_slot,
   output logic                 busy,
   output logic                 pix_valid,
   input  logic                 pix_ready,
   output logic [PIX_BITS-1:0]  pix_data,
   output logic                 pix_first,
   output logic                 pix_row_last,
   output logic                 pix_last,
   output logic                 done,
   output logic                 err
);

   localparam int PIX_CNT  = IMG_W * IMG_H;
   localparam int MEM_BITS = SLOT_BITS + ADDR_BITS;
   localparam int CNT_BITS = ADDR_BITS + 1;
   localparam int COL_BITS = $clog2(IMG_W + 1);
   localparam int ROW_BITS = $clog2(IMG_H + 1);

   typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

   state_t                state_q, state_d;
   logic [SLOT_BITS-1:0]  act_slot_q;
   logic [CNT_BITS-1:0]   rd_cnt_q;
   logic [COL_BITS-1:0]   col_q;
   logic [ROW_BITS-1:0]   row_q;
   logic [NUM_SLOTS-1:0]  loaded_q, loaded_d;
   logic                  err_q, err_d;

   logic                  vld_p1;
   logic [PIX_BITS-1:0]   rd_data_p1;
   logic                  vld_p2, skid_vld_p2;
   logic [PIX_BITS-1:0]   out_data_p2, skid_data_p2;

   logic [PIX_BITS-1:0]   mem [0:NUM_SLOTS*PIX_CNT-1];
   logic [MEM_BITS-1:0]   wr_idx, rd_idx;

   logic                  busy_w, beat, at_last, start_ok;
   logic                  wr_hit_active, wr_range_ok, wr_ok, rd_issue, end_beat;
   logic [1:0]            occ;

   always_comb begin
      busy_w        = (state_q == FILL) || (state_q == STREAM);
      beat          = vld_p2 && pix_ready;
      at_last       = (col_q == COL_BITS'(IMG_W - 1)) && (row_q == ROW_BITS'(IMG_H - 1));
      end_beat      = (state_q == STREAM) && beat && at_last;
      start_ok      = (state_q == IDLE) && start && loaded_q[start_slot];
      wr_hit_active = busy_w && (wr_slot == act_slot_q);
      wr_range_ok   = wr_addr < ADDR_BITS'(PIX_CNT);
      wr_ok         = wr_en && wr_range_ok && !wr_hit_active;
      err_d         = (start && busy_w)
                    || (start && (state_q == IDLE) && !loaded_q[start_slot])
                    || (wr_en && (!wr_range_ok || wr_hit_active))
                    || (wr_commit && wr_hit_active);
      // Items held or in flight never exceed the two output-side registers.
      occ           = {1'b0, vld_p1} + {1'b0, vld_p2} + {1'b0, skid_vld_p2};
      rd_issue      = busy_w && (rd_cnt_q < CNT_BITS'(PIX_CNT)) && ((occ != 2'd2) || beat);
      wr_idx        = MEM_BITS'(wr_slot) * MEM_BITS'(PIX_CNT) + MEM_BITS'(wr_addr);
      rd_idx        = MEM_BITS'(act_slot_q) * MEM_BITS'(PIX_CNT) + MEM_BITS'(rd_cnt_q);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_ok) state_d = FILL;
         FILL:    state_d = STREAM;
         STREAM:  if (end_beat) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      loaded_d = loaded_q;
      if (wr_commit && !wr_hit_active) loaded_d[wr_slot] = 1'b1;
      if (end_beat) loaded_d[act_slot_q] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         loaded_q    <= '0;
         err_q       <= 1'b0;
         act_slot_q  <= '0;
         rd_cnt_q    <= '0;
         col_q       <= '0;
         row_q       <= '0;
         vld_p1      <= 1'b0;
         vld_p2      <= 1'b0;
         skid_vld_p2 <= 1'b0;
      end else begin
         state_q  <= state_d;
         loaded_q <= loaded_d;
         err_q    <= err_d;
         vld_p1   <= rd_issue;
         if (start_ok) begin
            act_slot_q <= start_slot;
            rd_cnt_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
         end else begin
            if (rd_issue) rd_cnt_q <= rd_cnt_q + 1'b1;
            if (beat) begin
               if (col_q == COL_BITS'(IMG_W - 1)) begin
                  col_q <= '0;
                  row_q <= (row_q == ROW_BITS'(IMG_H - 1)) ? '0 : row_q + 1'b1;
               end else begin
                  col_q <= col_q + 1'b1;
               end
            end
         end
         if (beat || !vld_p2) begin
            if (skid_vld_p2) begin
               vld_p2      <= 1'b1;
               skid_vld_p2 <= vld_p1;
            end else begin
               vld_p2      <= vld_p1;
            end
         end else if (vld_p1) begin
            skid_vld_p2 <= 1'b1;
         end
      end
   end

   // Stage p1: RAM write port and registered read port
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_idx] <= wr_data;
      if (rd_issue) rd_data_p1 <= mem[rd_idx];
   end

   // Stage p2: output register with one-entry skid buffer
   always_ff @(posedge clk) begin
      if (beat || !vld_p2) begin
         if (skid_vld_p2) begin
            out_data_p2  <= skid_data_p2;
            skid_data_p2 <= rd_data_p1;
         end else begin
            out_data_p2  <= rd_data_p1;
         end
      end else if (vld_p1) begin
         skid_data_p2 <= rd_data_p1;
      end
   end

   assign slot_loaded  = loaded_q;
   assign busy         = busy_w;
   assign done         = (state_q == DONE);
   assign err          = err_q;
   assign pix_valid    = vld_p2;
   assign pix_data     = vld_p2 ? out_data_p2 : '0;
   assign pix_first    = vld_p2 && (col_q == '0) && (row_q == '0);
   assign pix_row_last = vld_p2 && (col_q == COL_BITS'(IMG_W - 1));
   assign pix_last     = vld_p2 && at_last;

endmodule
